// File: rtl/hex_tx_formatter.sv
// Prints a binary word as uppercase ASCII hex plus CR LF through a byte-wide UART transmitter.
// Build with HEX_TX_PREFIX_EN defined to send a leading "0x" before the digits.
module hex_tx_formatter #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [4*NIBBLES-1:0] data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_done_i
);

  localparam int DW = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 4);
`ifdef HEX_TX_PREFIX_EN
  localparam int PRE = 2;
`else
  localparam int PRE = 0;
`endif
  localparam int N = NIBBLES + 2 + PRE;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t          state_q;
  logic [DW-1:0]   sr_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic [7:0]      cur_char_s;
  logic            digit_s;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = 8'h30 + {4'h0, n};
    end else begin
      c = 8'h37 + {4'h0, n};
    end
    return c;
  endfunction

  // Character for the current counter position; the digit is always the top nibble.
  always_comb begin
    cur_char_s = 8'h00;
    if (cnt_q == CW'(PRE + NIBBLES)) begin
      cur_char_s = 8'h0D;
    end else if (cnt_q == CW'(PRE + NIBBLES + 1)) begin
      cur_char_s = 8'h0A;
`ifdef HEX_TX_PREFIX_EN
    end else if (cnt_q == CW'(0)) begin
      cur_char_s = 8'h30;
    end else if (cnt_q == CW'(1)) begin
      cur_char_s = 8'h78;
`endif
    end else begin
      cur_char_s = hex_char(sr_q[DW-1 -: 4]);
    end
  end

`ifdef HEX_TX_PREFIX_EN
  assign digit_s = (cnt_q >= CW'(PRE)) && (cnt_q < CW'(PRE + NIBBLES));
`else
  assign digit_s = (cnt_q < CW'(NIBBLES));
`endif

  // Sequencer: all outputs are registered, strobes default low every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            sr_q    <= data_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          tx_data_q  <= cur_char_s;
          tx_start_q <= 1'b1;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done_i) begin
            if (cnt_q == CW'(N - 1)) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              if (digit_s) begin
                sr_q <= sr_q << 3'd4;
              end else begin
                sr_q <= sr_q;
              end
              state_q <= S_LOAD;
            end
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_hex_tx_formatter.sv
// Directed and randomized bench for hex_tx_formatter with a transmitter responder and string model.
module tb_hex_tx_formatter;

  localparam int NIBBLES = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] data_i;
  logic        busy_o;
  logic        done_o;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_done_i;
  logic        tx_done_m;
  logic        tx_done_inj;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  int done_cnt    = 0;
  int resp_cnt    = 0;
  int consec_err  = 0;
  int stable_err  = 0;
  int resp_delay  = 10;
  bit prev_start  = 1'b0;
  logic [7:0] last_data = 8'h00;

  assign tx_done_i = tx_done_m | tx_done_inj;

  hex_tx_formatter #(.NIBBLES(NIBBLES)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .data_i     (data_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .tx_done_i  (tx_done_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Transmitter stand-in: answers each start strobe with a done tick; 0 delay means random.
  initial begin
    tx_done_m = 1'b0;
    forever begin
      @(negedge clk_i);
      if (tx_start_o && !rst_i) begin
        bit abort = 1'b0;
        int dly = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, 12));
        for (int k = 0; k < dly; k++) begin
          @(negedge clk_i);
          if (rst_i) abort = 1'b1;
        end
        if (!abort) begin
          tx_done_m = 1'b1;
          resp_cnt++;
          @(negedge clk_i);
          tx_done_m = 1'b0;
        end
      end
    end
  end

  // Output monitor: collects characters, done pulses, strobe spacing and data stability.
  initial begin
    forever begin
      @(negedge clk_i);
      if (tx_start_o) begin
        got_q.push_back(tx_data_o);
        if (prev_start) consec_err++;
        last_data = tx_data_o;
      end else if (busy_o) begin
        if (tx_data_o !== last_data) stable_err++;
      end else begin
        last_data = tx_data_o;
      end
      if (done_o) done_cnt++;
      prev_start = tx_start_o;
    end
  end

  task automatic build_exp(input logic [15:0] d, output logic [7:0] q[$]);
    q.delete();
`ifdef HEX_TX_PREFIX_EN
    q.push_back("0");
    q.push_back("x");
`endif
    for (int i = NIBBLES - 1; i >= 0; i--) begin
      int nib = int'((d >> (4 * i)) & 16'h000F);
      if (nib < 10) q.push_back(8'(48 + nib));
      else          q.push_back(8'(65 + (nib - 10)));
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  task automatic run_seq(input logic [15:0] d, input bit inject);
    logic [7:0] exp_q[$];
    bit seen = 1'b0;
    build_exp(d, exp_q);
    got_q.delete();
    done_cnt   = 0;
    consec_err = 0;
    stable_err = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    data_i  = d;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("busy_rise", busy_o, 1);
    chk("load_no_strobe", tx_start_o, 0);
    if (inject) begin
      start_i     = 1'b1;
      data_i      = 16'hFFFF;
      tx_done_inj = 1'b1;
    end
    @(negedge clk_i);
    start_i     = 1'b0;
    tx_done_inj = 1'b0;
    chk("first_strobe_latency", tx_start_o, 1);
    for (int c = 0; c < 1500 && !seen; c++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("busy_at_done", busy_o, 0);
    @(negedge clk_i);
    chk("busy_after_done", busy_o, 0);
    chk("done_one_cycle", done_o, 0);
    chk("done_count", done_cnt, 1);
    chk("char_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("char%0d_%h", i, d), (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD, exp_q[i]);
    chk("no_back_to_back_strobe", consec_err, 0);
    chk("data_stable_in_wait", stable_err, 0);
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    bit seen;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    data_i      = 16'h0000;
    tx_done_inj = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_tx_start", tx_start_o, 0);
    chk("rst_tx_data", tx_data_o, 8'h00);
    cnt_a = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      if (tx_start_o || busy_o) cnt_a++;
    end
    chk("idle_quiet", cnt_a, 0);

    resp_delay = 10;
    run_seq(16'hA5C3, 1'b0);
    run_seq(16'h09AF, 1'b0);
    run_seq(16'hFFFF, 1'b0);
    run_seq(16'h1234, 1'b1);
    run_seq(16'h00FF, 1'b0);

    resp_delay = 0;
    for (int r = 0; r < 6; r++) run_seq(16'($urandom), r[0]);

    // reset in the middle of a sequence
    got_q.delete();
    done_cnt = 0;
    resp_cnt = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    data_i  = 16'($urandom);
    @(negedge clk_i);
    start_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 1500 && !seen; c++) begin
      @(negedge clk_i);
      if (resp_cnt >= 2) seen = 1'b1;
    end
    chk("mid_two_done_seen", seen, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("mid_rst_strobe", tx_start_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (tx_start_o) cnt_a++;
      if (done_o || busy_o) cnt_b++;
    end
    chk("mid_rst_no_strobe", cnt_a, 0);
    chk("mid_rst_no_done", cnt_b + done_cnt, 0);
    chk("mid_rst_chars", got_q.size(), 2);
    run_seq(16'h0000, 1'b0);

    // start and reset together: reset wins
    @(negedge clk_i);
    start_i = 1'b1;
    rst_i   = 1'b1;
    data_i  = 16'h5A5A;
    @(negedge clk_i);
    start_i = 1'b0;
    rst_i   = 1'b0;
    chk("rst_wins_busy", busy_o, 0);
    cnt_a = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (tx_start_o || busy_o) cnt_a++;
    end
    chk("rst_wins_quiet", cnt_a, 0);
    run_seq(16'hC0DE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_tx_formatter.md
Name: hex_tx_formatter

Overview:
- Converts a binary word into printable ASCII hex followed by CR LF, and feeds the UART transmitter one character at a time.
- Sits directly upstream of the transmitter. It drives the transmitter's start strobe and data byte, and paces itself on the transmitter's end-of-transmission tick.
- Lets debug values (counters, FIFO data, status) be printed on a serial terminal without software.

Parameters:
- NIBBLES, 4, number of hex digits sent; input word width is 4*NIBBLES (legal 1..8).

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle request to print data_i; sampled only in IDLE.
- data_i  input  4*NIBBLES  word to print; captured on accepted start_i.
- busy_o  output  1  high from the cycle after accept until done_o.
- done_o  output  1  one-cycle pulse after the final character completes.
- tx_start_o  output  1  one-cycle start strobe to the transmitter.
- tx_data_o  output  8  ASCII byte for the transmitter.
- tx_done_i  input  1  one-cycle end-of-transmission tick from the transmitter.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset state: IDLE, busy_o=0, done_o=0, tx_start_o=0, tx_data_o=8'h00, shift register and character counter cleared.
- Character sequence: NIBBLES hex digits MSB nibble first, then 8'h0D, then 8'h0A. Total N = NIBBLES+2 characters.
- Digit encoding:
  - nibble 0-9 maps to 8'h30+n.
  - nibble 10-15 maps to 8'h41+(n-10), uppercase.
- FSM states: IDLE, LOAD, WAIT, DONE.
  - IDLE: on start_i=1, capture data_i into the shift register, clear the counter, go to LOAD. busy_o rises next cycle.
  - LOAD (1 cycle): drive tx_data_o with the current character, pulse tx_start_o=1, go to WAIT.
  - WAIT: hold tx_data_o stable.
    - On tx_done_i=1: if counter==N-1 go to DONE; otherwise increment the counter, shift the register left by 4 when the digit field is still active, and go to LOAD.
  - DONE (1 cycle): done_o=1, busy_o=0, return to IDLE. A new start_i can be accepted the cycle after DONE.
- Latency:
  - First tx_start_o appears 2 cycles after start_i is accepted.
  - Each subsequent tx_start_o appears 2 cycles after the matching tx_done_i.
- Boundary conditions:
  - start_i while not in IDLE is ignored; data_i is not re-captured.
  - tx_done_i outside WAIT is ignored and does not advance the counter.
  - tx_start_o never asserts in two consecutive cycles.
  - Counter width is clog2(NIBBLES+4); it never wraps during a sequence.
  - rst_i mid-sequence returns to IDLE immediately. No done_o is produced and the remaining characters are dropped. The transmitter shares rst_i, so no partial frame persists.
  - start_i and rst_i in the same cycle: reset wins.

Optional Feature:
- Macro: HEX_TX_PREFIX_EN.
- Defined: the characters 8'h30 ('0') and 8'h78 ('x') are sent before the digits. N = NIBBLES+4 and the counter is sized accordingly.
- Undefined: no prefix; N = NIBBLES+2.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> all outputs 0, busy_o=0, no tx_start_o for 100 cycles.
- Basic print: NIBBLES=4, data_i=16'hA5C3, start_i pulse; bench model returns tx_done_i 10 cycles after each tx_start_o.
  - tx_data_o sequence must be 41,35,43,33,0D,0A.
  - Exactly 6 tx_start_o pulses, then one done_o pulse.
  - busy_o must be low one cycle later.
- Digit boundaries: data_i=16'h09AF -> 30,39,41,46,0D,0A. Repeat with data_i=16'hFFFF -> 46,46,46,46,0D,0A.
- Ignored inputs: during a sequence on 16'h1234, pulse start_i with data_i=16'hFFFF and inject tx_done_i during a LOAD cycle -> output stays 31,32,33,34,0D,0A, no extra characters.
- Reset mid-operation: assert rst_i after the 2nd tx_done_i -> next cycle IDLE, tx_start_o=0, busy_o=0, no done_o. A fresh start with 16'h0000 then prints 30,30,30,30,0D,0A.
- Prefix build (HEX_TX_PREFIX_EN defined): data_i=16'h00FF -> 30,78,30,30,46,46,0D,0A, then done_o.
